// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and helpers for the round-robin grant controller
//   arb_state_t      : controller FSM encoding (IDLE, OWN, GAP)
//   onehot_to_index  : binary index of the highest set bit of a one-hot vector (up to 16 bits)
package rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  function automatic int unsigned onehot_to_index(input logic [15:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin winner selection
//   req     in  : request vector
//   last_id in  : index of the previous owner; scanning starts one above it
//   winner  out : index of the first requester at or after last_id+1 (mod NUM_REQ)
//   any_req out : at least one request is set
module rr_priority_picker
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_id,
  output logic [IDW-1:0]     winner,
  output logic               any_req
);

  // Two extra bits cover base (up to NUM_REQ) plus offset (up to NUM_REQ-1).
  localparam int SW = IDW + 2;

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SW-1:0]        base;
  logic [SW-1:0]        sum_raw;
  logic [IDW-1:0]       off;

  always_comb begin
    // Rotating the doubled vector right by last_id+1 places the highest
    // priority requester at bit 0, so find-first-set gives the offset.
    dbl  = {req, req};
    base = SW'(last_id) + SW'(1);
    rot  = NUM_REQ'(dbl >> base);
    off  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    sum_raw = base + SW'(off);
    winner  = (sum_raw >= SW'(NUM_REQ)) ? IDW'(sum_raw - SW'(NUM_REQ)) : IDW'(sum_raw);
    any_req = |req;
  end

endmodule

// File: rtl/rr_grant_controller.sv
// rtl/rr_grant_controller.sv - round-robin grant sequencer with hold limit and turnaround gap
//   clk         in  : system clock, rising edge
//   rst_n       in  : asynchronous active-low reset
//   req         in  : level-sensitive request vector
//   grant       out : registered one-hot grant, zero when no owner
//   grant_valid out : registered, high when grant is nonzero
//   grant_id    out : index of the current owner, holds last value while idle
//   preempt     out : one-cycle pulse when an owner is removed by timeout
module rr_grant_controller
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       preempt
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int HW  = $clog2(MAX_HOLD + 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               valid_q, valid_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [IDW-1:0]     last_id_q, last_id_d;
  logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
  logic               preempt_q, preempt_d;

  logic [IDW-1:0]     winner;
  logic               any_req;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req     (req),
    .last_id (last_id_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    valid_d    = valid_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;

    unique case (state_q)
      IDLE, GAP: begin
        if (any_req) begin
          state_d         = OWN;
          grant_d         = '0;
          grant_d[winner] = 1'b1;
          valid_d         = 1'b1;
          grant_id_d      = winner;
          hold_cnt_d      = HW'(1);
        end else begin
          state_d    = IDLE;
          grant_d    = '0;
          valid_d    = 1'b0;
          hold_cnt_d = '0;
        end
      end
      OWN: begin
        // Release is checked first so a drop on the last allowed cycle is
        // treated as a voluntary release, not a preemption.
        if (!req[grant_id_q] || (hold_cnt_q == HW'(MAX_HOLD))) begin
          state_d    = GAP;
          grant_d    = '0;
          valid_d    = 1'b0;
          last_id_d  = grant_id_q;
          hold_cnt_d = '0;
          preempt_d  = req[grant_id_q];
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        valid_d    = 1'b0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      valid_q    <= 1'b0;
      grant_id_q <= '0;
      last_id_q  <= IDW'(NUM_REQ - 1);
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      valid_q    <= valid_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = grant_id_q;
  assign preempt     = preempt_q;

`ifndef SYNTHESIS
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_valid_matches: assert property (@(posedge clk) disable iff (!rst_n) valid_q == (|grant_q));
  a_preempt_idle:  assert property (@(posedge clk) disable iff (!rst_n) preempt_q |-> !valid_q);
`endif

endmodule

// File: tb/tb_rr_grant_controller.sv
// tb/tb_rr_grant_controller.sv - scoreboard bench for rr_grant_controller
module tb_rr_grant_controller;
  import rr_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       preempt;

  always #5 clk = ~clk;

  rr_grant_controller #(
    .NUM_REQ  (4),
    .MAX_HOLD (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .preempt     (preempt)
  );

  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic       p;
    int         n;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] async_q[$];
  int         n_pass  = 0;
  int         n_total = 0;
  int         step_no = 0;
  bit         done    = 1'b0;

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic step(input logic rs, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] id, input logic p);
    exp_t e;
    @(negedge clk);
    rst_n = rs;
    req   = r;
    if (!rs) begin
      #1;
      async_q.push_back({grant, grant_valid});
    end
    e.g  = g;
    e.id = id;
    e.p  = p;
    e.n  = step_no;
    step_no++;
    exp_q.push_back(e);
  endtask

  initial begin : driver
    rst_n = 1'b0;
    req   = 4'b1111;
    // reset held with all requests pending
    repeat (3) step(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0);
    // full contention: 8 owned cycles then a preempting gap, order 0,1,2,3,0
    for (int k = 0; k < 4; k++) begin
      repeat (8) step(1'b1, 4'b1111, 4'(1 << k), 2'(k), 1'b0);
      step(1'b1, 4'b1111, 4'b0000, 2'(k), 1'b1);
    end
    step(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0);
    // release on the 8th owned cycle beats timeout
    repeat (8) step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
    step(1'b1, 4'b1101, 4'b0000, 2'd1, 1'b0);
    step(1'b1, 4'b1101, 4'b0100, 2'd2, 1'b0);
    // rotation skip after owner 3
    step(1'b1, 4'b1000, 4'b0000, 2'd2, 1'b0);
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0);
    step(1'b1, 4'b0011, 4'b0000, 2'd3, 1'b0);
    step(1'b1, 4'b0011, 4'b0001, 2'd0, 1'b0);
    step(1'b1, 4'b0010, 4'b0000, 2'd0, 1'b0);
    step(1'b1, 4'b1010, 4'b0010, 2'd1, 1'b0);
    step(1'b1, 4'b1000, 4'b0000, 2'd1, 1'b0);
    step(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd3, 1'b0);
    // single requester
    repeat (4) step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0);
    // reset pulse while requester 1 owns at hold count 4
    repeat (4) step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
    step(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0);
    repeat (8) step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
    step(1'b1, 4'b0010, 4'b0000, 2'd1, 1'b1);
    step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0);
    step(1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0);
    done = 1'b1;
  end

  initial begin : monitor
    exp_t       e;
    logic [4:0] a;
    int         cycles;
    cycles = 0;
    while (!(done && exp_q.size() == 0) && cycles < 2000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (async_q.size() > 0) begin
        a = async_q.pop_front();
        n_total++;
        if (a == 5'b00000) n_pass++;
        else $display("FAIL async_reset grant,valid=%b required 00000", a);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_total++;
        if (grant === e.g && grant_valid === (|e.g) && grant_id === e.id && preempt === e.p &&
            (!grant_valid || onehot_to_index({12'b0, grant}) == 32'(e.id)))
          n_pass++;
        else
          $display("FAIL step%0d grant=%b valid=%b id=%0d preempt=%b required grant=%b valid=%b id=%0d preempt=%b",
                   e.n, grant, grant_valid, grant_id, preempt, e.g, |e.g, e.id, e.p);
      end
    end
    if (cycles >= 2000) begin
      n_total++;
      $display("FAIL timeout cycles=%0d required completion before 2000", cycles);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
